// File: rtl/ip_codma_mem_responder_if.sv
// ----------------------------------------------------------------------------
// ip_codma_mem_responder_if
// Initiator <-> memory responder bus bundle.
//   req_i    : initiator request, held high for the whole transfer
//   wr_i     : 1 = write, 0 = read (sampled at acceptance)
//   addr_i   : byte address (sampled at acceptance)
//   size_i   : size code 3/8/9 -> 1/2/4 beats (sampled at acceptance)
//   wdata_i  : write data, sampled on every granted write beat
//   grant_o  : high on each active data beat
//   rvalid_o : read data valid, coincident with grant_o on read beats
//   rdata_o  : registered read data
//   error_o  : one-cycle error pulse for an illegal request
//   busy_o   : responder not idle
// master = initiator side, slave = responder side.
// ----------------------------------------------------------------------------
interface ip_codma_mem_responder_if;
   logic        req_i;
   logic        wr_i;
   logic [31:0] addr_i;
   logic [3:0]  size_i;
   logic [63:0] wdata_i;
   logic        grant_o;
   logic        rvalid_o;
   logic [63:0] rdata_o;
   logic        error_o;
   logic        busy_o;

   modport master (
      output req_i, wr_i, addr_i, size_i, wdata_i,
      input  grant_o, rvalid_o, rdata_o, error_o, busy_o
   );

   modport slave (
      input  req_i, wr_i, addr_i, size_i, wdata_i,
      output grant_o, rvalid_o, rdata_o, error_o, busy_o
   );
endinterface

// File: rtl/ip_codma_mem_responder.sv
// ----------------------------------------------------------------------------
// ip_codma_mem_responder
// Single-port 64-bit memory responder for the CODMA initiator. A request is
// accepted in idle, checked for legality, delayed by GRANT_LATENCY cycles and
// then served as 1, 2 or 4 consecutive granted beats. Reads use a lookahead
// registered fetch so rdata_o is valid in the same cycle as grant_o.
// Ports:
//   clk_i     : clock, rising edge
//   reset_n_i : asynchronous active-low reset (memory array is not reset)
//   bus       : ip_codma_mem_responder_if.slave (request/data/status signals)
// Parameters:
//   MEM_DEPTH     : number of 64-bit entries (power of two, 2..1024)
//   GRANT_LATENCY : cycles from acceptance edge to first grant (1..15)
// ----------------------------------------------------------------------------
module ip_codma_mem_responder #(
   parameter int unsigned MEM_DEPTH     = 64,
   parameter int unsigned GRANT_LATENCY = 2
) (
   input logic                     clk_i,
   input logic                     reset_n_i,
   ip_codma_mem_responder_if.slave bus
);

   localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int unsigned LAT_W  = 4;
   localparam int unsigned BEAT_W = 3;

   typedef enum logic [1:0] {
      RSP_IDLE   = 2'd0,
      RSP_WAIT   = 2'd1,
      RSP_ACTIVE = 2'd2,
      RSP_ERROR  = 2'd3
   } rsp_state_e;

   rsp_state_e          state_q, state_d;

   // Captured request
   logic                wr_q;
   logic [IDX_W-1:0]    base_q;
   logic [BEAT_W-1:0]   nbeats_q;

   // Counters
   logic [LAT_W-1:0]    lat_q, lat_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;

   // Registered outputs
   logic                grant_q, grant_d;
   logic                rvalid_q, rvalid_d;
   logic                error_q, error_d;
   logic                busy_q, busy_d;
   logic [63:0]         rdata_q;

   // Datapath controls
   logic                cap_en;
   logic                rd_en;
   logic [IDX_W-1:0]    rd_idx;
   logic                wr_en;
   logic [IDX_W-1:0]    wr_idx;

   // Request decode
   logic [BEAT_W-1:0]   req_beats_c;
   logic [31:0]         req_last_c;
   logic                req_illegal_c;

   logic [63:0]         mem [MEM_DEPTH];

   // Beat count from size code and legality of the incoming request
   always_comb begin
      req_beats_c = '0;
      case (bus.size_i)
         4'd3:    req_beats_c = BEAT_W'(1);
         4'd8:    req_beats_c = BEAT_W'(2);
         4'd9:    req_beats_c = BEAT_W'(4);
         default: req_beats_c = '0;
      endcase
      req_last_c    = 32'(bus.addr_i[31:3]) + 32'(req_beats_c) - 32'd1;
      req_illegal_c = (req_beats_c == '0) ||
                      (bus.addr_i[2:0] != 3'b000) ||
                      (req_last_c >= 32'(MEM_DEPTH));
   end

   // State register
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= RSP_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; req_i dropping mid-transfer aborts back to idle
   always_comb begin
      state_d = state_q;
      case (state_q)
         RSP_IDLE: begin
            if (bus.req_i) begin
               state_d = req_illegal_c ? RSP_ERROR : RSP_WAIT;
            end
         end
         RSP_WAIT: begin
            if (!bus.req_i) begin
               state_d = RSP_IDLE;
            end else if (lat_q == '0) begin
               state_d = RSP_ACTIVE;
            end
         end
         RSP_ACTIVE: begin
            if (!bus.req_i || (beat_q == nbeats_q - BEAT_W'(1))) begin
               state_d = RSP_IDLE;
            end
         end
         RSP_ERROR: state_d = RSP_IDLE;
         default:   state_d = RSP_IDLE;
      endcase
   end

   // Output/control logic; outputs are computed from the next state and
   // registered so they line up with the state they describe
   always_comb begin
      cap_en   = 1'b0;
      lat_d    = lat_q;
      beat_d   = beat_q;
      wr_en    = 1'b0;
      wr_idx   = base_q + IDX_W'(beat_q);
      rd_idx   = base_q;
      busy_d   = (state_d != RSP_IDLE);
      error_d  = (state_d == RSP_ERROR);
      grant_d  = (state_d == RSP_ACTIVE);
      case (state_q)
         RSP_IDLE: begin
            cap_en = bus.req_i;
            // WAIT lasts GRANT_LATENCY cycles, counting down to zero
            lat_d  = LAT_W'(GRANT_LATENCY - 1);
            beat_d = '0;
         end
         RSP_WAIT: begin
            if (lat_q != '0) begin
               lat_d = lat_q - LAT_W'(1);
            end
         end
         RSP_ACTIVE: begin
            wr_en  = bus.req_i & wr_q;
            beat_d = beat_q + BEAT_W'(1);
            // Lookahead: fetch the entry for the next beat
            rd_idx = base_q + IDX_W'(beat_q) + IDX_W'(1);
         end
         default: ;
      endcase
      rvalid_d = grant_d & ~wr_q;
      rd_en    = rvalid_d;
   end

   // Output registers, request capture, counters and read data
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         grant_q  <= 1'b0;
         rvalid_q <= 1'b0;
         error_q  <= 1'b0;
         busy_q   <= 1'b0;
         rdata_q  <= '0;
         lat_q    <= '0;
         beat_q   <= '0;
         wr_q     <= 1'b0;
         base_q   <= '0;
         nbeats_q <= '0;
      end else begin
         grant_q  <= grant_d;
         rvalid_q <= rvalid_d;
         error_q  <= error_d;
         busy_q   <= busy_d;
         lat_q    <= lat_d;
         beat_q   <= beat_d;
         if (cap_en) begin
            wr_q     <= bus.wr_i;
            base_q   <= IDX_W'(bus.addr_i[31:3]);
            nbeats_q <= req_beats_c;
         end
         if (rd_en) begin
            rdata_q <= mem[rd_idx];
         end
      end
   end

   // Memory array, not reset; writes qualify on the reset-cleared state
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem[wr_idx] <= bus.wdata_i;
      end
   end

   assign bus.grant_o  = grant_q;
   assign bus.rvalid_o = rvalid_q;
   assign bus.rdata_o  = rdata_q;
   assign bus.error_o  = error_q;
   assign bus.busy_o   = busy_q;

endmodule

// File: tb/tb_ip_codma_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_ip_codma_mem_responder
// Scoreboard bench: each transfer pushes its expected read data / error
// tokens into queues from an array memory model; an independent monitor pops
// and compares whenever rvalid_o or error_o is presented. The driver checks
// grant/busy/error cycle timing derived from latency and beat count.
// ----------------------------------------------------------------------------
module tb_ip_codma_mem_responder;

   localparam int unsigned DEPTH = 64;
   localparam int unsigned LAT   = 2;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;

   always #5 clk = ~clk;

   ip_codma_mem_responder_if bus_if ();

   ip_codma_mem_responder #(
      .MEM_DEPTH     (DEPTH),
      .GRANT_LATENCY (LAT)
   ) dut (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .bus       (bus_if)
   );

   int errors = 0;
   int checks = 0;

   logic [63:0] mem_m [DEPTH];
   logic [63:0] exp_rd [$];
   int          exp_err [$];
   logic [63:0] exp_hold;
   logic [63:0] wbuf [4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops scoreboard entries whenever the DUT presents read data or an error
   initial begin
      exp_hold = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            exp_hold = '0;
         end else begin
            if (bus_if.rvalid_o) begin
               check1("rvalid_with_grant", bus_if.grant_o, 1'b1);
               check1("rvalid_expected", exp_rd.size() > 0, 1'b1);
               if (exp_rd.size() > 0) begin
                  exp_hold = exp_rd.pop_front();
                  check("rdata", bus_if.rdata_o, exp_hold);
               end
            end else begin
               check("rdata_hold", bus_if.rdata_o, exp_hold);
            end
            if (bus_if.error_o) begin
               check1("error_expected", exp_err.size() > 0, 1'b1);
               if (exp_err.size() > 0) void'(exp_err.pop_front());
            end
         end
      end
   end

   // mode 0: full transfer; 1: drop req_i on beat 'cut'; 2: reset on beat 'cut'
   task automatic xfer(input bit wr, input logic [31:0] addr, input logic [3:0] size,
                       input int mode, input int cut);
      int n;
      int base;
      bit legal;
      int shown;
      int wr_beats;
      int last_k;
      bit exp_g;
      bit exp_b;
      n = (size == 4'd3) ? 1 : (size == 4'd8) ? 2 : (size == 4'd9) ? 4 : 0;
      base  = int'(addr[31:3]);
      legal = (n != 0) && (addr[2:0] == 3'b000) && (base + n <= int'(DEPTH));
      shown    = !legal ? 0 : ((mode != 0) ? cut + 1 : n);
      wr_beats = (mode != 0) ? cut : n;
      if (!legal) begin
         exp_err.push_back(1);
      end else if (!wr) begin
         for (int b = 0; b < n; b++) exp_rd.push_back(mem_m[base + b]);
      end else begin
         for (int b = 0; b < wr_beats; b++) mem_m[base + b] = wbuf[b];
      end

      @(negedge clk);
      bus_if.req_i  = 1'b1;
      bus_if.wr_i   = wr;
      bus_if.addr_i = addr;
      bus_if.size_i = size;
      last_k = legal ? int'(LAT) + shown : 1;
      for (int k = 0; k <= last_k; k++) begin
         @(negedge clk);
         exp_g = legal && (k >= int'(LAT)) && (k < int'(LAT) + shown);
         exp_b = legal ? (k < int'(LAT) + shown) : (k == 0);
         check1("grant", bus_if.grant_o, exp_g);
         check1("busy", bus_if.busy_o, exp_b);
         check1("error", bus_if.error_o, !legal && (k == 0));
         if (!legal && k == 0) bus_if.req_i = 1'b0;
         if (exp_g) begin
            if (mode != 0 && (k - int'(LAT)) == cut) begin
               if (mode == 1) begin
                  bus_if.req_i = 1'b0;
               end else begin
                  #2 reset_n = 1'b0;
                  #1;
                  check1("rst_grant", bus_if.grant_o, 1'b0);
                  check1("rst_rvalid", bus_if.rvalid_o, 1'b0);
                  check1("rst_error", bus_if.error_o, 1'b0);
                  check1("rst_busy", bus_if.busy_o, 1'b0);
                  check("rst_rdata", bus_if.rdata_o, 64'd0);
                  repeat (2) @(negedge clk);
                  bus_if.req_i = 1'b0;
                  reset_n = 1'b1;
                  return;
               end
            end else if (wr) begin
               bus_if.wdata_i = wbuf[k - int'(LAT)];
            end
         end
      end
      bus_if.req_i = 1'b0;
   endtask

   task automatic rand_wbuf();
      for (int i = 0; i < 4; i++) wbuf[i] = {$urandom, $urandom};
   endtask

   // Watchdog
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [3:0]  size_tab [8];
      logic [31:0] a;
      logic [3:0]  s;
      bit          w;
      int          n;
      int          m;
      size_tab = '{4'd3, 4'd8, 4'd9, 4'd3, 4'd8, 4'd9, 4'd5, 4'd0};

      bus_if.req_i   = 1'b0;
      bus_if.wr_i    = 1'b0;
      bus_if.addr_i  = '0;
      bus_if.size_i  = '0;
      bus_if.wdata_i = '0;

      // Reset state
      #2 reset_n = 1'b0;
      #1;
      check1("reset_grant", bus_if.grant_o, 1'b0);
      check1("reset_rvalid", bus_if.rvalid_o, 1'b0);
      check1("reset_error", bus_if.error_o, 1'b0);
      check1("reset_busy", bus_if.busy_o, 1'b0);
      check("reset_rdata", bus_if.rdata_o, 64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Fill the whole memory so the model is fully defined
      for (int i = 0; i < int'(DEPTH) / 4; i++) begin
         rand_wbuf();
         xfer(1'b1, 32'(i * 32), 4'd9, 0, 0);
      end

      // 4-beat write of 1..4 at 0x40 then read back (also read-after-write)
      for (int i = 0; i < 4; i++) wbuf[i] = 64'(i + 1);
      xfer(1'b1, 32'h40, 4'd9, 0, 0);
      xfer(1'b0, 32'h40, 4'd9, 0, 0);

      // Illegal size code, memory at 0 unchanged
      rand_wbuf();
      xfer(1'b1, 32'h0, 4'd5, 0, 0);
      xfer(1'b0, 32'h0, 4'd9, 0, 0);

      // Range overflow at the last entry, then legal single beat there
      xfer(1'b1, 32'h1F8, 4'd8, 0, 0);
      xfer(1'b1, 32'h1F8, 4'd3, 0, 0);
      xfer(1'b0, 32'h1F8, 4'd3, 0, 0);
      xfer(1'b0, 32'h1F0, 4'd8, 0, 0);

      // Misaligned address
      xfer(1'b0, 32'h44, 4'd3, 0, 0);

      // Abort a 4-beat write on beat 2
      rand_wbuf();
      xfer(1'b1, 32'h80, 4'd9, 1, 2);
      xfer(1'b0, 32'h80, 4'd9, 0, 0);

      // Reset during an active write on beat 2
      rand_wbuf();
      xfer(1'b1, 32'hC0, 4'd9, 2, 2);
      xfer(1'b0, 32'hC0, 4'd9, 0, 0);

      // Randomized traffic
      for (int it = 0; it < 120; it++) begin
         rand_wbuf();
         w = 1'($urandom_range(0, 1));
         s = size_tab[$urandom_range(0, 7)];
         a = 32'($urandom_range(0, 70)) << 3;
         if ($urandom_range(0, 7) == 0) a[2:0] = 3'($urandom_range(1, 7));
         n = (s == 4'd3) ? 1 : (s == 4'd8) ? 2 : (s == 4'd9) ? 4 : 0;
         m = (w && n != 0 && $urandom_range(0, 3) == 0) ? 1 : 0;
         xfer(w, a, s, m, (m != 0) ? int'($urandom_range(0, n - 1)) : 0);
      end

      // Final read sweep of the whole memory
      for (int i = 0; i < int'(DEPTH) / 4; i++) xfer(1'b0, 32'(i * 32), 4'd9, 0, 0);

      repeat (3) @(negedge clk);
      check("rd_queue_drained", 64'(exp_rd.size()), 64'd0);
      check("err_queue_drained", 64'(exp_err.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
